// File: rtl/meduram_rd_arbiter.sv
// meduram_rd_arbiter: round-robin share of one multi-bank RAM read port with halt/drain FSM.
// Optional MEDURAM_RDARB_PERF_EN adds per-requester 16-bit saturating wait counters on perf_wait.
module meduram_rd_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NB_RDREQ   = 4,
  parameter int RD_LATENCY = 1,
  parameter int ID_WIDTH   = (NB_RDREQ == 1) ? 1 : $clog2(NB_RDREQ)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NB_RDREQ-1:0]            req_valid,
  input  logic [NB_RDREQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NB_RDREQ-1:0]            req_ready,
  output logic                           ram_rden,
  output logic [ADDR_WIDTH-1:0]          ram_rdaddr,
  input  logic [DATA_WIDTH-1:0]          ram_rddata,
  output logic [NB_RDREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  input  logic                           halt_req,
  output logic                           halted
`ifdef MEDURAM_RDARB_PERF_EN
  ,output logic [NB_RDREQ*16-1:0]        perf_wait
`endif
);
  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, win, idx, id_q;
  logic found, hs, rden_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RD_LATENCY-1:0] tv_q;
  logic [RD_LATENCY-1:0][ID_WIDTH-1:0] tid_q;
  always_comb begin
    found = 1'b0;
    win = rr_q;
    idx = '0;
    for (int i = 1; i <= NB_RDREQ; i++) begin
      idx = ID_WIDTH'((int'(rr_q) + i) % NB_RDREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // reset also masks grants so nothing is offered while the port is held in reset
  assign hs = found && state_q == RUN && !areset;
  assign req_ready = hs ? NB_RDREQ'(1) << win : '0;
  assign ram_rden = rden_q;
  assign ram_rdaddr = addr_q;
  assign rsp_valid = tv_q[RD_LATENCY-1] ? NB_RDREQ'(1) << tid_q[RD_LATENCY-1] : '0;
  assign rsp_data = ram_rddata;
  assign halted = state_q == HALT;
  always_comb begin
    state_d = !halt_req ? RUN :
              (state_q == RUN) ? DRAIN :
              (!rden_q && !(|tv_q)) ? HALT : state_q;
  end
  // rden_q/id_q is the RAM issue stage; tv_q/tid_q then follows the RAM latency
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= RUN;
      rr_q <= ID_WIDTH'(NB_RDREQ - 1);
      rden_q <= 1'b0;
      addr_q <= '0;
      id_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
    end else begin
      state_q <= state_d;
      rden_q <= hs;
      if (hs) begin
        rr_q <= win;
        addr_q <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        id_q <= win;
      end
      tv_q[0] <= rden_q;
      tid_q[0] <= id_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tv_q[i] <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
    end
  end
`ifdef MEDURAM_RDARB_PERF_EN
  for (genvar g = 0; g < NB_RDREQ; g++) begin : g_perf
    logic [15:0] cnt_q;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) cnt_q <= '0;
      else if (req_valid[g] && !req_ready[g] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign perf_wait[g*16 +: 16] = cnt_q;
  end
`endif
endmodule
